// File: rtl/i8080_regfile_pkg.sv
// Purpose: shared encodings for the 8080 register file, control FSM and ALU.
// Latency: n/a (constants only).
// Backpressure: n/a.
package i8080_regfile_pkg;

  // Byte register codes (8080 SSS/DDD field)
  localparam logic [2:0] REG_B = 3'b000;
  localparam logic [2:0] REG_C = 3'b001;
  localparam logic [2:0] REG_D = 3'b010;
  localparam logic [2:0] REG_E = 3'b011;
  localparam logic [2:0] REG_H = 3'b100;
  localparam logic [2:0] REG_L = 3'b101;
  localparam logic [2:0] REG_M = 3'b110;
  localparam logic [2:0] REG_A = 3'b111;

  // Register pair codes
  localparam logic [1:0] RP_BC = 2'b00;
  localparam logic [1:0] RP_DE = 2'b01;
  localparam logic [1:0] RP_HL = 2'b10;
  localparam logic [1:0] RP_SP = 2'b11;

  // Pair operations
  localparam logic [1:0] RP_NOP   = 2'b00;
  localparam logic [1:0] RP_WRITE = 2'b01;
  localparam logic [1:0] RP_INC   = 2'b10;
  localparam logic [1:0] RP_DEC   = 2'b11;

endpackage

// File: rtl/register.sv
// Purpose: generic loadable register cell with synchronous active-low reset.
// Latency: 1 cycle from wenable/in to out.
// Backpressure: none; accepts a load every cycle.
// Ports: clk, rst_n (sync, active-low), wenable (load strobe), in (next value), out (stored value).
module register #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wenable,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= RESET;
    end else if (wenable) begin
      out <= in;
    end
  end

endmodule

// File: rtl/i8080_regfile.sv
// Purpose: 8080 architectural registers B,C,D,E,H,L,A and SP with pair access, INX/DCX, XCHG.
// Latency: reads combinational from current state; every write commits on the next rising edge.
// Backpressure: none; all requests are accepted each cycle, conflicts resolved by fixed priority.
// Ports: clk, rst_n (sync, active-low); rd_a_sel/rd_a, rd_b_sel/rd_b byte reads;
//        wr_en/wr_sel/wr_data byte write; rp_sel/rp_op/rp_din/rp_dout pair access;
//        xchg (DE<->HL swap); sp_out, hl_out direct views.
module i8080_regfile
  import i8080_regfile_pkg::*;
#(
  parameter logic [15:0] SP_RESET  = 16'h0000,
  parameter logic [7:0]  REG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  rd_a_sel,
  output logic [7:0]  rd_a,
  input  logic [2:0]  rd_b_sel,
  output logic [7:0]  rd_b,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [7:0]  wr_data,
  input  logic [1:0]  rp_sel,
  input  logic [1:0]  rp_op,
  input  logic [15:0] rp_din,
  output logic [15:0] rp_dout,
  input  logic        xchg,
  output logic [15:0] sp_out,
  output logic [15:0] hl_out
);

  // Byte registers indexed by their 3-bit code; slot 6 (M) is a constant zero.
  logic [7:0][7:0] cur;
  logic [15:0]     sp;

  logic [15:0] rp_val;
  logic [15:0] incdec;
  logic [15:0] pair_new;
  logic        pair_act;
  logic        sp_we;

  always_comb begin
    rp_val = sp;
    case (rp_sel)
      RP_BC:   rp_val = {cur[REG_B], cur[REG_C]};
      RP_DE:   rp_val = {cur[REG_D], cur[REG_E]};
      RP_HL:   rp_val = {cur[REG_H], cur[REG_L]};
      default: rp_val = sp;
    endcase
  end

  // Single shared incrementer/decrementer on the selected pair.
  assign incdec   = (rp_op == RP_DEC) ? (rp_val - 16'd1) : (rp_val + 16'd1);
  assign pair_new = (rp_op == RP_WRITE) ? rp_din : incdec;

  // XCHG owns D,E,H,L this edge, so a pair op aimed at DE or HL is dropped.
  assign pair_act = (rp_op != RP_NOP) && !(xchg && ((rp_sel == RP_DE) || (rp_sel == RP_HL)));
  assign sp_we    = pair_act && (rp_sel == RP_SP);

  for (genvar k = 0; k < 8; k++) begin : g_byte
    if (k == 6) begin : g_m
      assign cur[k] = 8'h00;
    end else begin : g_reg
      localparam logic [2:0] CODE    = 3'(k);
      localparam bit         IS_SWAP = (k >= 2) && (k <= 5);

      logic       we;
      logic [7:0] nxt;

      // Later assignments override earlier ones: byte write < pair op < xchg.
      always_comb begin
        we  = 1'b0;
        nxt = wr_data;
        if (wr_en && (wr_sel == CODE)) begin
          we = 1'b1;
        end
        // Pair code matches the upper two bits of its byte codes; A (111) maps to SP and is excluded.
        if (pair_act && (rp_sel != RP_SP) && (rp_sel == CODE[2:1])) begin
          we  = 1'b1;
          nxt = CODE[0] ? pair_new[7:0] : pair_new[15:8];
        end
        // D<->H and E<->L differ only in bits 2:1 of the code (010<->100, 011<->101).
        if (IS_SWAP && xchg) begin
          we  = 1'b1;
          nxt = cur[CODE ^ 3'b110];
        end
      end

      register #(.WIDTH(8), .RESET(REG_RESET)) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .wenable (we),
        .in      (nxt),
        .out     (cur[k])
      );
    end
  end

  register #(.WIDTH(16), .RESET(SP_RESET)) u_sp (
    .clk     (clk),
    .rst_n   (rst_n),
    .wenable (sp_we),
    .in      (pair_new),
    .out     (sp)
  );

  assign rd_a    = cur[rd_a_sel];
  assign rd_b    = cur[rd_b_sel];
  assign rp_dout = rp_val;
  assign sp_out  = sp;
  assign hl_out  = {cur[REG_H], cur[REG_L]};

endmodule
